// File: rtl/set_member_enum_pkg.sv
// Shared types and helpers for the set-member enumerator.
package set_member_pkg;

    // FSM encoding; also carried on the interface as a debug view of the state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Widest bitmap the helper handles (WIDTH up to 8)
    localparam int MAX_BITS = 256;
    typedef logic [MAX_BITS-1:0] set_map_t;

    // True when any bitmap bit at position idx or higher is set
    function automatic logic any_at_or_above(input set_map_t bitmap, input int unsigned idx);
        return (bitmap >> idx) != '0;
    endfunction

endpackage

// File: rtl/set_member_enum_if.sv
// Command and output-stream bundle of the set-member enumerator.
//
// Stream handshake: a member transfers on a cycle where out_valid and
// out_ready are both high at the rising clock edge. While out_valid is high
// and out_ready is low, out_value and out_last hold stable. out_valid never
// depends on out_ready; out_ready while out_valid is low has no effect.
interface set_member_enum_if #(
    parameter int WIDTH = 4
);
    import set_member_pkg::*;
    localparam int CNT_W = WIDTH + 1;

    logic             clr;
    logic             add_valid;
    logic [WIDTH-1:0] add_value;
    logic             start;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_value;
    logic             out_last;
    logic             done;
    logic             wr_drop;
    logic [CNT_W-1:0] count;
    state_e           state;

    modport master (
        output clr, add_valid, add_value, start, out_ready,
        input  busy, out_valid, out_value, out_last, done, wr_drop, count, state
    );

    modport slave (
        input  clr, add_valid, add_value, start, out_ready,
        output busy, out_valid, out_value, out_last, done, wr_drop, count, state
    );

endinterface

// File: rtl/set_member_enum_store.sv
// Set storage: a bitmap over the value universe plus a registered member count.
module set_member_store #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = WIDTH + 1,
    localparam int SIZE  = 2 ** WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             add_valid,
    input  logic [WIDTH-1:0] add_value,
    input  logic             freeze,
    output logic [SIZE-1:0]  bitmap,
    output logic [CNT_W-1:0] count
);

    // clr wins over add; re-adding an existing member leaves count alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap <= '0;
            count  <= '0;
        end else if (!freeze) begin
            if (clr) begin
                bitmap <= '0;
                count  <= '0;
            end else if (add_valid && !bitmap[add_value]) begin
                bitmap[add_value] <= 1'b1;
                count             <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/set_member_enum.sv
// Streams the members of a programmable small-integer set in ascending order.
module set_member_enum #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = WIDTH + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    set_member_enum_if.slave   bus
);
    import set_member_pkg::*;

    localparam int SIZE = 2 ** WIDTH;

    logic [1:0]       state_q;
    logic [CNT_W-1:0] idx;
    logic [WIDTH-1:0] idx_lo;
    logic [SIZE-1:0]  bitmap;
    logic             cur_bit;
    logic             more_here;
    logic             more_above;
    logic             out_valid;
    logic             out_last;
    logic             busy;
    logic             wr_drop_q;

    assign busy   = (state_q != ST_IDLE);
    assign idx_lo = idx[WIDTH-1:0];

    set_member_store #(.WIDTH(WIDTH)) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (bus.clr),
        .add_valid (bus.add_valid),
        .add_value (bus.add_value),
        .freeze    (busy),
        .bitmap    (bitmap),
        .count     (bus.count)
    );

    assign cur_bit    = bitmap[idx_lo];
    assign more_here  = any_at_or_above(set_map_t'(bitmap), 32'(idx));
    assign more_above = any_at_or_above(set_map_t'(bitmap), 32'(idx) + 32'd1);

    assign out_valid = (state_q == ST_SCAN) && cur_bit;
    assign out_last  = out_valid && !more_above;

    assign bus.busy      = busy;
    assign bus.out_valid = out_valid;
    assign bus.out_value = out_valid ? idx_lo : '0;
    assign bus.out_last  = out_last;
    assign bus.done      = (state_q == ST_DONE);
    assign bus.wr_drop   = wr_drop_q;
    assign bus.state     = state_e'(state_q);

    // Scan walks idx upward one index per cycle, stalling on a member until it is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q <= ST_SCAN;
                        idx     <= '0;
                    end
                end
                ST_SCAN: begin
                    if (cur_bit) begin
                        if (bus.out_ready) begin
                            if (out_last) state_q <= ST_DONE;
                            else          idx     <= idx + CNT_W'(1);
                        end
                    end else if (!more_here) begin
                        state_q <= ST_DONE;
                    end else begin
                        idx <= idx + CNT_W'(1);
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Flag any write or start request that arrives while the set is frozen
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) wr_drop_q <= 1'b0;
        else        wr_drop_q <= busy && (bus.clr || bus.add_valid || bus.start);
    end

endmodule

// File: tb/tb_set_member_enum.sv
// Directed bench for set_member_enum with a scoreboard on the output stream.
module tb_set_member_enum;
    localparam int WIDTH = 4;

    logic clk;
    logic rst_n;

    set_member_enum_if #(.WIDTH(WIDTH)) bus ();

    set_member_enum #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;
    logic [WIDTH:0] exp_q[$];   // {last, value}

    int done_cnt  = 0;
    int busy_cnt  = 0;
    int valid_cnt = 0;
    logic             prev_stall = 1'b0;
    logic             prev_last;
    logic [WIDTH-1:0] prev_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [WIDTH-1:0] v);
        bus.add_valid = 1'b1;
        bus.add_value = v;
        tick();
        bus.add_valid = 1'b0;
    endtask

    task automatic push_exp(input logic last, input logic [WIDTH-1:0] v);
        exp_q.push_back({last, v});
    endtask

    task automatic wait_done(input string tag, output int n);
        n = 0;
        while (!bus.done && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    endtask

    // monitor: scoreboard pops, hold-stability and event counters
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (bus.done)      done_cnt++;
            if (bus.busy)      busy_cnt++;
            if (bus.out_valid) valid_cnt++;
            if (prev_stall)
                chk("hold", 32'({bus.out_valid, bus.out_last, bus.out_value}),
                    32'({1'b1, prev_last, prev_val}));
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_last  = bus.out_last;
            prev_val   = bus.out_value;
            if (bus.out_valid && bus.out_ready) begin
                total++;
                assert (exp_q.size() > 0) else begin
                    bad++;
                    $error("FAIL unexpected_out observed=%0h expected=none", bus.out_value);
                end
                if (exp_q.size() > 0)
                    chk("sb_out", 32'({bus.out_last, bus.out_value}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        int n;
        int dc;
        int vc;

        rst_n         = 1'b0;
        bus.clr       = 1'b0;
        bus.add_valid = 1'b0;
        bus.add_value = '0;
        bus.start     = 1'b0;
        bus.out_ready = 1'b0;

        // reset state
        repeat (3) tick();
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_value", 32'(bus.out_value), 32'd0);
        chk("rst_out_last",  32'(bus.out_last),  32'd0);
        chk("rst_done",      32'(bus.done),      32'd0);
        chk("rst_wr_drop",   32'(bus.wr_drop),   32'd0);
        chk("rst_count",     32'(bus.count),     32'd0);
        rst_n = 1'b1;
        tick();

        // consecutive members 2..5 with ready held high
        add(4'd2); add(4'd3); add(4'd4); add(4'd5);
        chk("t1_count", 32'(bus.count), 32'd4);
        push_exp(1'b0, 4'd2); push_exp(1'b0, 4'd3);
        push_exp(1'b0, 4'd4); push_exp(1'b1, 4'd5);
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("t1_first_lat", 32'(n), 32'd3);
        chk("t1_first_val", 32'(bus.out_value), 32'd2);
        wait_done("t1", n);
        chk("t1_done_lat", 32'(n), 32'd4);
        chk("t1_q_empty", 32'(exp_q.size()), 32'd0);
        tick();
        chk("t1_idle", 32'(bus.busy), 32'd0);
        chk("t1_count_after", 32'(bus.count), 32'd4);

        // empty set after reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        busy_cnt = 0;
        done_cnt = 0;
        vc = valid_cnt;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("t2", n);
        chk("t2_done_lat", 32'(1 + n), 32'd2);
        repeat (3) tick();
        chk("t2_busy_cycles", 32'(busy_cnt), 32'd2);
        chk("t2_done_pulses", 32'(done_cnt), 32'd1);
        chk("t2_no_valid", 32'(valid_cnt - vc), 32'd0);

        // {0,15} with back-pressure on the first member
        add(4'd0); add(4'd15);
        push_exp(1'b0, 4'd0); push_exp(1'b1, 4'd15);
        bus.out_ready = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t3_stall_valid", 32'(bus.out_valid), 32'd1);
            chk("t3_stall_value", 32'(bus.out_value), 32'd0);
            chk("t3_stall_last",  32'(bus.out_last),  32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!(bus.out_valid && bus.out_value == 4'd15) && n < 60);
        chk("t3_skip_lat", 32'(n), 32'd15);
        chk("t3_last15", 32'(bus.out_last), 32'd1);
        wait_done("t3", n);
        chk("t3_q_empty", 32'(exp_q.size()), 32'd0);
        tick();

        // writes while busy are dropped
        push_exp(1'b0, 4'd0); push_exp(1'b1, 4'd15);
        bus.out_ready = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        add(4'd7);
        chk("t4_wr_drop", 32'(bus.wr_drop), 32'd1);
        tick();
        chk("t4_wr_drop_pulse", 32'(bus.wr_drop), 32'd0);
        chk("t4_count_frozen", 32'(bus.count), 32'd2);
        bus.out_ready = 1'b1;
        wait_done("t4", n);
        chk("t4_q_empty", 32'(exp_q.size()), 32'd0);
        tick();
        // clr and add together in IDLE
        bus.clr       = 1'b1;
        bus.add_valid = 1'b1;
        bus.add_value = 4'd9;
        tick();
        bus.clr       = 1'b0;
        bus.add_valid = 1'b0;
        chk("t4_clr_count", 32'(bus.count), 32'd0);
        chk("t4_clr_no_drop", 32'(bus.wr_drop), 32'd0);
        vc = valid_cnt;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("t4e", n);
        chk("t4_empty_no_valid", 32'(valid_cnt - vc), 32'd0);
        tick();

        // duplicate add, then add coinciding with start
        add(4'd6);
        chk("t5_count_a", 32'(bus.count), 32'd1);
        add(4'd6);
        chk("t5_count_b", 32'(bus.count), 32'd1);
        push_exp(1'b0, 4'd1); push_exp(1'b1, 4'd6);
        bus.out_ready = 1'b1;
        bus.add_valid = 1'b1;
        bus.add_value = 4'd1;
        bus.start     = 1'b1;
        tick();
        bus.add_valid = 1'b0;
        bus.start     = 1'b0;
        wait_done("t5", n);
        chk("t5_count_c", 32'(bus.count), 32'd2);
        chk("t5_q_empty", 32'(exp_q.size()), 32'd0);
        tick();

        // asynchronous reset while member 4 is on the output
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        add(4'd4);
        bus.out_ready = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 1;
        while (!bus.out_valid && n < 40) begin
            tick();
            n++;
        end
        chk("t6_first_lat", 32'(n), 32'd5);
        chk("t6_value", 32'(bus.out_value), 32'd4);
        dc = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_valid", 32'(bus.out_valid), 32'd0);
        chk("t6_async_busy",  32'(bus.busy),      32'd0);
        chk("t6_async_count", 32'(bus.count),     32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("t6_no_done", 32'(done_cnt - dc), 32'd0);
        chk("t6_idle", 32'(bus.busy), 32'd0);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
